// File: rtl/cryption_pkg.sv
// Shared constants and types for the byte-stream encryption/decryption pair:
// default keys, key-rotation length, key-index type and the bit-permutation map.
package cryption_pkg;

  localparam int CNT_MAX = 3;

  localparam logic [7:0] K1_DEFAULT = 8'h3E;
  localparam logic [7:0] K2_DEFAULT = 8'h49;
  localparam logic [7:0] K3_DEFAULT = 8'h7E;

  typedef logic [1:0] kidx_t;

  localparam kidx_t KIDX_K1 = 2'd0;
  localparam kidx_t KIDX_K2 = 2'd1;
  localparam kidx_t KIDX_K3 = 2'd2;

  // Encrypt-side map: permuted bit i is taken from input bit PERM_SRC[i].
  // Decryption uses the inverse map.
  localparam logic [2:0] PERM_SRC [8] = '{3'd1, 3'd3, 3'd4, 3'd7, 3'd6, 3'd2, 3'd5, 3'd0};

  function automatic logic [7:0] key_default(input kidx_t k);
    logic [7:0] key;
    key = 8'h00;
    case (k)
      KIDX_K1: key = K1_DEFAULT;
      KIDX_K2: key = K2_DEFAULT;
      KIDX_K3: key = K3_DEFAULT;
      default: key = 8'h00;
    endcase
    return key;
  endfunction

  // Next key index in the rotation, wrapping after cnt_max-1.
  function automatic kidx_t kidx_next(input kidx_t k, input int cnt_max);
    kidx_t nxt;
    if (k == kidx_t'(cnt_max - 1)) nxt = KIDX_K1;
    else                           nxt = k + 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/encryption_perm.sv
// Combinational byte permutation used ahead of the key XOR; the bit map
// lives in cryption_pkg so the decryption side can share it.
module encryption_perm
  import cryption_pkg::*;
(
  input  logic [7:0] d,
  output logic [7:0] p
);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign p[i] = d[PERM_SRC[i]];
  end

endmodule

// File: rtl/encryption.sv
// Two-stage pipelined byte encryptor: permute, then XOR with a round-robin key.
// Optional runtime key loading is enabled with `define ENCRYPTION_KEY_LOAD_EN.
module encryption #(
  parameter int N       = 8,
  parameter int CNT_MAX = cryption_pkg::CNT_MAX
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         in_valid,
  input  logic         sop,
  output logic         in_ready,
  output logic [N-1:0] dout,
  output logic         out_valid,
  input  logic         out_ready
`ifdef ENCRYPTION_KEY_LOAD_EN
  ,
  input  logic         key_we,
  input  logic [1:0]   key_sel,
  input  logic [N-1:0] key_wdata
`endif
);

  import cryption_pkg::*;

  // Handshake: a byte transfers on any edge where valid && ready are both high;
  // valid never waits for ready, and dout/out_valid hold while out_ready is low.
  logic         accept;
  logic         s2_load;
  logic         s1_adv;
  logic [N-1:0] perm_byte;
  kidx_t        kidx;
  kidx_t        use_kidx;
  logic         s1_valid;
  logic [N-1:0] s1_data;
  kidx_t        s1_kidx;
  logic [N-1:0] s1_key;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  // Held high through reset so the source never sees a stall while flushing.
  assign in_ready = rst || !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;
  assign use_kidx = sop ? KIDX_K1 : kidx;

  encryption_perm u_perm (
    .d (din),
    .p (perm_byte)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      kidx <= KIDX_K1;
    end else if (accept) begin
      kidx <= kidx_next(use_kidx, CNT_MAX);
    end
  end

  // Stage 1: the key index is bound here so stalls cannot shift the rotation.
  always_ff @(posedge clock) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_kidx  <= KIDX_K1;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= perm_byte;
      s1_kidx  <= use_kidx;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

`ifdef ENCRYPTION_KEY_LOAD_EN
  logic [N-1:0] k1_q;
  logic [N-1:0] k2_q;
  logic [N-1:0] k3_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      k1_q <= K1_DEFAULT;
      k2_q <= K2_DEFAULT;
      k3_q <= K3_DEFAULT;
    end else if (key_we) begin
      case (key_sel)
        2'd0:    k1_q <= key_wdata;
        2'd1:    k2_q <= key_wdata;
        2'd2:    k3_q <= key_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    s1_key = '0;
    case (s1_kidx)
      KIDX_K1: s1_key = k1_q;
      KIDX_K2: s1_key = k2_q;
      KIDX_K3: s1_key = k3_q;
      default: s1_key = '0;
    endcase
  end
`else
  assign s1_key = key_default(s1_kidx);
`endif

  // Stage 2: output register; only reloads when downstream can take a byte.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dout <= s1_data ^ s1_key;
      end
    end
  end

endmodule

// File: tb/tb_encryption.sv
// Self-checking bench for encryption: directed vector table, stall/reset
// sequences and randomized traffic scored against a behavioural model.
module tb_encryption;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       in_valid;
  logic       sop;
  logic       in_ready;
  logic [7:0] dout;
  logic       out_valid;
  logic       out_ready;
`ifdef ENCRYPTION_KEY_LOAD_EN
  logic       key_we;
  logic [1:0] key_sel;
  logic [7:0] key_wdata;
`endif

  always #5 clock = ~clock;

  encryption dut (
    .clock     (clock),
    .rst       (rst),
    .din       (din),
    .in_valid  (in_valid),
    .sop       (sop),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ENCRYPTION_KEY_LOAD_EN
    ,
    .key_we    (key_we),
    .key_sel   (key_sel),
    .key_wdata (key_wdata)
`endif
  );

  typedef struct {
    logic       sop;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [9];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q [$];
  logic [7:0] ref_key [3];
  int         ref_k;
  bit         use_model;
  logic [7:0] tab_exp;
  bit         prev_stall;
  logic [7:0] prev_dout;
  int         first_fire_cyc;
  int         acc_cyc;
  int         a0;
  int         n;
  bit         acc;
  logic [7:0] bytes [4];

  function automatic logic [7:0] ref_perm(input logic [7:0] d);
    int         src [8] = '{0, 5, 2, 6, 7, 4, 3, 1};
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) p[7-i] = d[src[i]];
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ref_k          = 0;
    ref_key[0]     = 8'h3E;
    ref_key[1]     = 8'h49;
    ref_key[2]     = 8'h7E;
    prev_stall     = 1'b0;
    first_fire_cyc = -1;
  endtask

  // One clock cycle: drive, sample after settling, score, advance to next negedge.
  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic ordy, output bit accepted);
    int         idx;
    logic [7:0] e;
    in_valid  = v;
    sop       = s;
    din       = d;
    out_ready = ordy;
    #1;
    if (prev_stall) check("stall_hold", {23'd0, out_valid, dout}, {23'd0, 1'b1, prev_dout});
    if (out_valid && out_ready) begin
      if (first_fire_cyc < 0) first_fire_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got %0h expected no output (cycle %0d)", dout, cyc);
      end else begin
        check("dout", dout, exp_q.pop_front());
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_dout  = dout;
    accepted   = in_valid && in_ready;
    if (accepted) begin
      idx   = s ? 0 : ref_k;
      e     = ref_perm(d) ^ ref_key[idx];
      ref_k = (idx + 1) % 3;
      exp_q.push_back(use_model ? e : tab_exp);
      acc_cyc = cyc;
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    sop       = 1'b0;
    din       = 8'h00;
    out_ready = 1'b1;
`ifdef ENCRYPTION_KEY_LOAD_EN
    key_we    = 1'b0;
    key_sel   = 2'd0;
    key_wdata = 8'h00;
`endif
    #1;
    check("in_ready_during_reset", in_ready, 1);
    @(negedge clock);
    cyc++;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_dout", dout, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clock);
    cyc++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid); i++) step(0, 0, 8'h00, 1, a);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h00, 8'h3E};
    vecs[1] = '{1'b0, 8'h00, 8'h49};
    vecs[2] = '{1'b1, 8'h00, 8'h3E};
    vecs[3] = '{1'b1, 8'h00, 8'h3E};
    vecs[4] = '{1'b0, 8'h00, 8'h49};
    vecs[5] = '{1'b0, 8'h00, 8'h7E};
    vecs[6] = '{1'b0, 8'h00, 8'h3E};
    vecs[7] = '{1'b1, 8'h01, 8'hBE};
    vecs[8] = '{1'b1, 8'h80, 8'h36};
    use_model = 1'b1;
    do_reset();
    check("idle_in_ready", in_ready, 1);

    // Directed table, back to back with out_ready high.
    use_model = 1'b0;
    a0 = -1;
    for (int i = 0; i < 9; i++) begin
      tab_exp = vecs[i].exp;
      step(1, vecs[i].sop, vecs[i].din, 1, acc);
      check("vec_accept", acc, 1);
      if (i == 0) a0 = acc_cyc;
    end
    use_model = 1'b1;
    drain();
    check("first_latency", first_fire_cyc - a0, 2);

    // Backpressure: only two bytes absorbed, then release and drain in order.
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom_range(0, 255));
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, (n == 0), bytes[n], 0, acc);
      if (acc) n++;
    end
    check("stall_accepts", n, 2);
    #1;
    check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 10 && n < 4; i++) begin
      step(1, 0, bytes[n], 1, acc);
      if (acc) n++;
    end
    check("release_accepts", n, 4);
    drain();

    // Reset with two bytes in flight; next byte without sop must use K1.
    step(1, 0, 8'hA5, 0, acc);
    step(1, 0, 8'h5A, 0, acc);
    do_reset();
    use_model = 1'b0;
    tab_exp   = 8'h3E;
    step(1, 0, 8'h00, 1, acc);
    a0 = acc_cyc;
    use_model = 1'b1;
    drain();
    check("post_reset_latency", first_fire_cyc - a0, 2);

`ifdef ENCRYPTION_KEY_LOAD_EN
    key_we = 1'b1; key_sel = 2'd0; key_wdata = 8'hFF;
    step(0, 0, 8'h00, 1, acc);
    ref_key[0] = 8'hFF;
    key_sel = 2'd3; key_wdata = 8'h55;
    step(0, 0, 8'h00, 1, acc);
    key_we = 1'b0;
    use_model = 1'b0;
    tab_exp   = 8'hFF;
    step(1, 1, 8'h00, 1, acc);
    tab_exp   = 8'h49;
    step(1, 0, 8'h00, 1, acc);
    use_model = 1'b1;
    drain();
    do_reset();
    use_model = 1'b0;
    tab_exp   = 8'h3E;
    step(1, 1, 8'h00, 1, acc);
    use_model = 1'b1;
    drain();
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
           8'($urandom_range(0, 255)), ($urandom_range(0, 9) < 6), acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encryption.md
# encryption

Byte-stream encryptor, the transmit-side counterpart of the team's decryption block. Each accepted plaintext byte is first bit-permuted, then XORed with one of three round-robin keys (K1, K2, K3), so that the decryption block recovers the original byte exactly. It sits between the plaintext source and the link. Both sides use ready/valid handshakes with full-throughput, two-stage pipelining and backpressure.

## Interface
Parameters:
- N, 8, data width; only 8 is supported.
- CNT_MAX, 3, number of keys in the rotation.

Ports:
- clock  in  1  single clock for all logic.
- rst  in  1  reset, synchronous and active-high (one clock; reset is synchronous and active-high).
- din  in  N  plaintext byte.
- in_valid  in  1  din is valid.
- sop  in  1  start of frame, qualified by in_valid; forces this byte to use K1.
- in_ready  out  1  block can accept din this cycle.
- dout  out  N  ciphertext byte.
- out_valid  out  1  dout is valid.
- out_ready  in  1  downstream accepts dout.
- key_we, key_sel[1:0], key_wdata[N-1:0]  in  runtime key write. These ports exist only with ENCRYPTION_KEY_LOAD_EN.

## Operation
- Permutation: p = {d[0],d[5],d[2],d[6],d[7],d[4],d[3],d[1]}, concatenated MSB first, where d is din. This is the inverse of the decryption permutation.
- XOR: c = p ^ K[kidx], with K1=8'h3E, K2=8'h49, K3=8'h7E.
- Key index counter kidx (2 bits, values 0..CNT_MAX-1):
  - It is sampled at accept, meaning in_valid && in_ready.
  - A byte accepted with sop=1 uses index 0, and kidx becomes 1.
  - A byte accepted with sop=0 uses kidx, then kidx increments and wraps from 2 to 0.
  - kidx holds when no byte is accepted.
- Stage 1 registers s1_data (the permuted byte), s1_kidx and s1_valid.
- Stage 2 registers dout = s1_data ^ K[s1_kidx] and out_valid.
- Flow control:
  - s2_load = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_load.
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready.
- out_valid deasserts after a consumed byte when no new byte arrives behind it.
- dout holds its value while out_valid && !out_ready.

## Timing
- Reset values:
  - dout = 0, out_valid = 0.
  - s1_valid = 0, s1_data = 0, kidx = 0.
  - in_ready = 1 during and after reset.
  - Keys return to their defaults.
- Latency: a byte accepted at rising edge E drives dout/out_valid from edge E+1 onward, i.e. it is visible in the cycle after E+1.
- Throughput: one byte per cycle while out_ready=1.
- Stall: with out_ready=0 the block absorbs at most 2 bytes (stage 1 and stage 2), then in_ready=0. No byte is dropped or duplicated.
- Order: the key is bound at accept time, so stalls never change which key a byte uses.
- Reset mid-operation: in-flight bytes are discarded, the next accepted byte uses K1, and sop is not required.
- sop on consecutive bytes: every such byte uses K1.

## Configuration
- ENCRYPTION_KEY_LOAD_EN defined:
  - The three keys are registers, reset to the defaults.
  - key_we writes key_wdata into K[key_sel]; key_sel=3 is ignored.
  - A write takes effect at the next edge. A byte in stage 1 during the write cycle uses the old key value.
- ENCRYPTION_KEY_LOAD_EN undefined:
  - Keys are constants.
  - The key_we, key_sel and key_wdata ports are absent.

## Structure
- Package cryption_pkg holds:
  - the K1/K2/K3 defaults and CNT_MAX;
  - the key-index typedef (2-bit);
  - the permutation index constants shared with decryption.
- Sub-module encryption_perm is a combinational byte permutation, instantiated once. It is reusable by a later decryption cleanup.

## Test plan
- After reset, send din 0x00 x4 with sop on the first byte and out_ready=1 -> dout 0x3E, 0x49, 0x7E, 0x3E, back to back, first byte 2 edges after accept.
- din 0x01 then 0x80 with sop=1 on each -> dout 0xBE, then 0x36.
- Send 0x00, 0x00, then 0x00 with sop=1 -> dout 0x3E, 0x49, 0x3E, showing the sop resync.
- Hold out_ready=0 and push 4 bytes -> in_ready drops after 2 accepts and dout is stable. Release out_ready -> all 4 bytes emerge in order with the keys in sequence.
- Assert rst with 2 bytes in flight -> out_valid=0 next cycle. The next byte 0x00 -> dout 0x3E.
- With ENCRYPTION_KEY_LOAD_EN: write key_sel=0, wdata=0xFF, then send 0x00 with sop -> dout 0xFF. Loopback through decryption loaded with the same key returns 0x00.
